// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared types and constants for the shift-and-add multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

   localparam int W_DEF = 4;
   localparam int CNT_W = $clog2(W_DEF + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ADD   = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/shift_add_mult_ctrl_adder.sv
`default_nettype none
// ============================================================================
// Module      : mult_adder_w / full_adder
// Description : W-bit ripple-carry adder built from full-adder cells, cin = 0.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module mult_adder_w #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         c_out
);
   logic [W:0] w_c;

   assign w_c[0] = 1'b0;

   for (genvar i = 0; i < W; i++) begin : g_fa
      full_adder u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (w_c[i]),
         .s  (sum[i]),
         .co (w_c[i+1])
      );
   end

   assign c_out = w_c[W];
endmodule
`default_nettype wire

// File: rtl/shift_add_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_mult_ctrl
// Description : Sequential unsigned shift-and-add multiplier, one shared adder.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_mult_ctrl
   import mult_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [W-1:0]   multiplicand,
   input  logic [W-1:0]   multiplier,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] product
);
   localparam int P_W = cnt_width(W);

   state_t           r_state;
   state_t           w_next;
   logic [W-1:0]     r_a;
   logic [W-1:0]     r_q;
   logic [W-1:0]     r_b;
   logic             r_c;
   logic [P_W-1:0]   r_p;
   logic [2*W-1:0]   r_product;
   logic [W-1:0]     w_sum;
   logic             w_cout;

   mult_adder_w #(.W(W)) u_adder (
      .a     (r_a),
      .b     (r_b),
      .sum   (w_sum),
      .c_out (w_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      busy   = (r_state != S_IDLE);
      done   = (r_state == S_DONE);
      case (r_state)
         S_IDLE:  if (start) w_next = S_ADD;
         S_ADD:   w_next = S_SHIFT;
         S_SHIFT: w_next = (r_p == '0) ? S_DONE : S_ADD;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // The exit test sees P after the ADD decrement, so P never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a       <= '0;
         r_q       <= '0;
         r_b       <= '0;
         r_c       <= 1'b0;
         r_p       <= '0;
         r_product <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_b <= multiplicand;
                  r_q <= multiplier;
                  r_a <= '0;
                  r_c <= 1'b0;
                  r_p <= P_W'(W);
               end
            end
            S_ADD: begin
               if (r_q[0]) begin
                  r_a <= w_sum;
                  r_c <= w_cout;
               end
               r_p <= r_p - P_W'(1);
            end
            S_SHIFT: begin
               r_c <= 1'b0;
               r_a <= {r_c, r_a[W-1:1]};
               r_q <= {r_a[0], r_q[W-1:1]};
               if (r_p == '0) r_product <= {r_c, r_a, r_q[W-1:1]};
            end
            default: ;
         endcase
      end
   end

   assign product = r_product;

endmodule
`default_nettype wire
